coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
Front-end stage that conditions the two raw coin-mechanism sensor lines, one for 5c and one for 10c, and feeds the vending state machine's 2-bit coin input. The state machine adds a coin's value on every cycle the code is non-zero, so this block converts each physical insertion into exactly one single-cycle code. Bounce and glitches are filtered, simultaneous or disabled insertions are rejected, and rejections are counted.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronized samples required before a sensor's debounced level changes (legal range 2..15)
CNT_W, 4, width of the debounce counters (must hold DEB_CYCLES)
REJ_W, 8, width of the saturating reject counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
raw_5  input  1  asynchronous 5c sensor; high while a coin passes
raw_10  input  1  asynchronous 10c sensor; high while a coin passes
accept_en  input  1  1 = coins accepted; 0 = every insertion is rejected
coin  output  2  to vending FSM: 00 none, 01 5c, 10 10c; 11 never driven
coin_reject  output  1  one-cycle pulse when an insertion is returned
reject_count  output  REJ_W  saturating count of rejections

Behaviour:
- Reset: one clock and one reset only. Reset is synchronous and active-high: rst sampled high at a clk rising edge clears all state. After reset: coin=00, coin_reject=0, reject_count=0, sync flops=0, debounced levels=0, debounce counters=0.
- Synchronizer: each raw line passes through a 2-flop synchronizer. No logic reads a raw line directly.
- Debounce, per channel: hold level L (reset 0) and counter C.
  - Each cycle where the synced value equals L: C is cleared to 0.
  - Each cycle where the synced value differs from L: C increments.
  - When C reaches DEB_CYCLES-1 and the synced value still differs: L flips and C clears.
  - A pulse shorter than DEB_CYCLES synced cycles never changes L.
- Event: ev_x = L_x rose this cycle (0->1 transition, registered). Falling edges produce nothing.
- Arbitration, combinational on events, result registered into the outputs:
  - ev_5 only, accept_en=1 -> coin=01 for exactly one cycle.
  - ev_10 only, accept_en=1 -> coin=10 for exactly one cycle.
  - ev_5 and ev_10 in the same cycle -> coin=00, coin_reject=1 for one cycle (one reject, not two).
  - Any event while accept_en=0 -> coin=00, coin_reject=1.
  - An event on one channel while the other channel's L=1 (jam) -> coin=00, coin_reject=1.
  - No event -> coin=00, coin_reject=0.
- coin and coin_reject are registered outputs and are never both non-zero in the same cycle.
- Latency: raw line first sampled high at edge k and held >= DEB_CYCLES+2 cycles -> coin valid in the cycle after edge k+DEB_CYCLES+2. With DEB_CYCLES=4 that is valid after edge k+6, i.e. 7 edges after first sample including the output edge.
- A coin held high for any length yields exactly one code. A new code requires L to return to 0 (DEB_CYCLES stable low samples), then rise again.
- reject_count increments on each coin_reject pulse and saturates at all-ones (no wrap).
- accept_en is sampled in the same cycle as the event. Toggling it while a coin is mid-debounce affects only the decision at the event cycle.
- Reset mid-operation: any pending debounce is discarded. A raw line still high after reset release is treated as a fresh insertion and produces a code after the full latency. reject_count clears.

Decomposition:
- Shared package coin_pkg: 2-bit coin code constants COIN_NONE=00, COIN_5=01, COIN_10=10. The vending FSM imports the same constants.
- One sub-module, coin_debounce (parameter DEB_CYCLES, CNT_W; ports clk, rst, raw, level, rise): contains the synchronizer, counter and edge detect. It is instantiated twice, once per channel.
- Top level holds arbitration, output registers and reject counter.

Test Plan:
- Clean 5c insertion (DEB_CYCLES=4): raw_5 high for 20 cycles, accept_en=1 -> coin=01 for exactly 1 cycle at edge k+6, then 00; coin_reject stays 0.
- Bounce: raw_10 toggling 1,0,1,1,0,1 in single cycles, then high 10 cycles -> exactly one coin=10 pulse, counted from the start of the stable run; glitch-only bursts of 3 cycles -> no output.
- Simultaneous insertion: raw_5 and raw_10 rise on the same edge, held 10 cycles -> coin stays 00, one coin_reject pulse, reject_count=1.
- Disabled acceptance: accept_en=0, raw_5 insertion -> coin_reject pulse, coin=00. Then accept_en=1 with a second raw_5 insertion (after 4+ low cycles) -> coin=01.
- Saturation: 260 rejected insertions with REJ_W=8 -> reject_count=255 and holds.
- Reset mid-debounce: raw_5 rises, rst pulsed 1 cycle two edges later, raw_5 held high -> coin=01 once, full latency measured from reset release.

Source files
------------

// File: rtl/coin_pkg.sv
// Coin code constants shared by the coin front end and the vending state machine.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10
  } coin_t;

  // Saturating increment for the reject counter; never wraps past all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchronizer, stable-count debounce and registered rising-edge event.
// rise is high for the single cycle after the debounced level goes 0->1.
module coin_debounce #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rise_q;
  logic             rise_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    // Any sample agreeing with the held level restarts the stability count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// Turns each physical coin insertion into one single-cycle coin code, or one reject pulse
// when the insertion is simultaneous, jammed against the other channel, or acceptance is off.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned REJ_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw_5,
  input  logic             raw_10,
  input  logic             accept_en,
  output logic [1:0]       coin,
  output logic             coin_reject,
  output logic [REJ_W-1:0] reject_count
);

  logic level_5;
  logic level_10;
  logic rise_5;
  logic rise_10;

  coin_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb_5 (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_5),
    .level (level_5),
    .rise  (rise_5)
  );

  coin_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb_10 (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_10),
    .level (level_10),
    .rise  (rise_10)
  );

  coin_t            coin_q;
  coin_t            coin_d;
  logic             reject_q;
  logic             reject_d;
  logic [REJ_W-1:0] rej_cnt_q;
  logic [REJ_W-1:0] rej_cnt_d;
  logic             any_ev;
  logic             bad_ev;

  assign any_ev = rise_5 | rise_10;
  // A simultaneous pair also shows the other level high, so it lands in the jam terms.
  assign bad_ev = !accept_en
                | (rise_5 & rise_10)
                | (rise_5 & level_10)
                | (rise_10 & level_5);

  always_comb begin
    coin_d   = COIN_NONE;
    reject_d = 1'b0;
    if (any_ev) begin
      if (bad_ev) begin
        reject_d = 1'b1;
      end else if (rise_5) begin
        coin_d = COIN_5;
      end else begin
        coin_d = COIN_10;
      end
    end
  end

  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (reject_d && (rej_cnt_q != {REJ_W{1'b1}})) begin
      rej_cnt_d = rej_cnt_q + REJ_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coin_q    <= COIN_NONE;
      reject_q  <= 1'b0;
      rej_cnt_q <= '0;
    end else begin
      coin_q    <= coin_d;
      reject_q  <= reject_d;
      rej_cnt_q <= rej_cnt_d;
    end
  end

  assign coin         = coin_q;
  assign coin_reject  = reject_q;
  assign reject_count = rej_cnt_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench: expected outputs are queued with their cycle when stimulus is driven.
module tb_coin_acceptor;
  import coin_pkg::*;

  typedef struct {
    logic [1:0] code;
    logic       rej;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw_5;
  logic       raw_10;
  logic       accept_en;
  logic [1:0] coin;
  logic       coin_reject;
  logic [7:0] reject_count;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;
  int   exp_rej = 0;
  exp_t sb[$];

  coin_acceptor #(
    .DEB_CYCLES (4),
    .CNT_W      (4),
    .REJ_W      (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raw_5        (raw_5),
    .raw_10       (raw_10),
    .accept_en    (accept_en),
    .coin         (coin),
    .coin_reject  (coin_reject),
    .reject_count (reject_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && (coin !== 2'b00 || coin_reject !== 1'b0)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output coin=%b reject=%b at cyc %0d, expected idle", coin, coin_reject, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (coin !== e.code || coin_reject !== e.rej || cyc != e.cyc) begin
          errors++;
          $display("FAIL output coin=%b reject=%b cyc=%0d, expected coin=%b reject=%b cyc=%0d",
                   coin, coin_reject, cyc, e.code, e.rej, e.cyc);
        end
      end
    end
  end

  // Full latency: a line driven now is first sampled next edge; output lands 6 edges later.
  task automatic push(input logic [1:0] code, input logic rej);
    exp_t e;
    e.code = code;
    e.rej  = rej;
    e.cyc  = cyc + 7;
    sb.push_back(e);
    if (rej && exp_rej != 255) exp_rej++;
  endtask

  task automatic hold(input logic r5, input logic r10, input int n);
    raw_5  = r5;
    raw_10 = r10;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; raw_5 = 1'b0; raw_10 = 1'b0; accept_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (coin !== 2'b00) begin errors++; $display("FAIL reset_coin got %b want 00", coin); end
    checks++;
    if (coin_reject !== 1'b0) begin errors++; $display("FAIL reset_reject got %b want 0", coin_reject); end
    checks++;
    if (reject_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", reject_count); end
    rst = 1'b0;
    exp_rej = 0;
    mon_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_clean_5();
    accept_en = 1'b1;
    push(COIN_5, 1'b0);
    hold(1'b1, 1'b0, 20);
    hold(1'b0, 1'b0, 10);
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL clean5_pending got %0d want 0", sb.size()); sb.delete(); end
    checks++;
    if (reject_count !== 8'(exp_rej)) begin errors++; $display("FAIL clean5_count got %0d want %0d", reject_count, exp_rej); end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    pat = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) push(COIN_10, 1'b0);
      hold(1'b0, pat[5-i], 1);
    end
    hold(1'b0, 1'b1, 9);
    hold(1'b0, 1'b0, 8);
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 1'b0, 3);
      hold(1'b0, 1'b0, 3);
      hold(1'b0, 1'b1, 3);
      hold(1'b0, 1'b0, 3);
    end
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL bounce_pending got %0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_simultaneous();
    push(COIN_NONE, 1'b1);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b0, 8);
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL simul_pending got %0d want 0", sb.size()); sb.delete(); end
    checks++;
    if (reject_count !== 8'd1) begin errors++; $display("FAIL simul_count got %0d want 1", reject_count); end
  endtask

  task automatic test_jam();
    push(COIN_10, 1'b0);
    hold(1'b0, 1'b1, 8);
    push(COIN_NONE, 1'b1);
    hold(1'b1, 1'b1, 8);
    hold(1'b0, 1'b0, 8);
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL jam_pending got %0d want 0", sb.size()); sb.delete(); end
    checks++;
    if (reject_count !== 8'(exp_rej)) begin errors++; $display("FAIL jam_count got %0d want %0d", reject_count, exp_rej); end
  endtask

  task automatic test_disabled();
    accept_en = 1'b0;
    push(COIN_NONE, 1'b1);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 8);
    accept_en = 1'b1;
    push(COIN_5, 1'b0);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 8);
    // Only the value at the event cycle matters.
    accept_en = 1'b0;
    push(COIN_5, 1'b0);
    hold(1'b1, 1'b0, 3);
    accept_en = 1'b1;
    hold(1'b1, 1'b0, 7);
    hold(1'b0, 1'b0, 8);
    push(COIN_NONE, 1'b1);
    hold(1'b0, 1'b1, 3);
    accept_en = 1'b0;
    hold(1'b0, 1'b1, 7);
    accept_en = 1'b1;
    hold(1'b0, 1'b0, 8);
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL disabled_pending got %0d want 0", sb.size()); sb.delete(); end
    checks++;
    if (reject_count !== 8'(exp_rej)) begin errors++; $display("FAIL disabled_count got %0d want %0d", reject_count, exp_rej); end
  endtask

  task automatic test_reset_mid();
    accept_en = 1'b1;
    hold(1'b1, 1'b0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rej = 0;
    checks++;
    if (reject_count !== 8'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", reject_count); end
    push(COIN_5, 1'b0);
    hold(1'b1, 1'b0, 12);
    hold(1'b0, 1'b0, 8);
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rstmid_pending got %0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_saturation();
    accept_en = 1'b0;
    for (int i = 0; i < 260; i++) begin
      push(COIN_NONE, 1'b1);
      hold(1'b1, 1'b0, 8);
      hold(1'b0, 1'b0, 8);
      if (i == 253 || i == 254) begin
        checks++;
        if (reject_count !== 8'(exp_rej)) begin
          errors++;
          $display("FAIL sat_count_%0d got %0d want %0d", i, reject_count, exp_rej);
        end
      end
    end
    accept_en = 1'b1;
    drain();
    checks++;
    if (reject_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", reject_count); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sat_pending got %0d want 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; raw_5 = 1'b0; raw_10 = 1'b0; accept_en = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_clean_5();
    test_bounce();
    test_simultaneous();
    test_jam();
    test_disabled();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
